// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter feeding one synchronous FIFO, in bursts of up to MAX_BURST beats.
// Define FIFO_ARB_STALL_CNT_EN to build the saturating full-stall cycle counter.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned OW        = $clog2(NUM_REQ),
  localparam int unsigned BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          busy,
  output logic [OW-1:0]                 owner,
  output logic [15:0]                   stall_cnt
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e        state_q;
  logic [OW-1:0] grant_idx_q;
  logic [OW-1:0] last_idx_q;
  logic [BW-1:0] beat_cnt_q;

  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic          found;
  logic          any_req;
  logic          owner_req;
  logic          beat;
  logic          burst_end;

  assign any_req   = |req;
  assign busy      = (state_q == StBurst);
  assign owner     = busy ? grant_idx_q : '0;
  assign owner_req = req[grant_idx_q];
  assign beat      = busy & owner_req & ~fifo_full;
  assign burst_end = (beat && (beat_cnt_q == BW'(MAX_BURST - 1))) || !owner_req;

  // Scan starts just past last_idx so the previous winner is considered last.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((32'(last_idx_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    ack       = '0;
    fifo_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (busy && (grant_idx_q == OW'(i))) begin
        ack[i]    = beat;
        fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign fifo_wr_cs = beat;
  assign fifo_wr_en = beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      last_idx_q  <= OW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StBurst;
            grant_idx_q <= pick;
            beat_cnt_q  <= '0;
            last_idx_q  <= pick;
          end
        end
        StBurst: begin
          if (burst_end) begin
            beat_cnt_q <= '0;
            if (any_req) begin
              grant_idx_q <= pick;
              last_idx_q  <= pick;
            end else begin
              state_q <= StIdle;
            end
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + BW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (busy && owner_req && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        fifo_full;
  logic        fifo_wr_cs;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic        busy;
  logic [1:0]  owner;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr_cs(fifo_wr_cs),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data (fifo_data),
    .busy      (busy),
    .owner     (owner),
    .stall_cnt (stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      total++;
      if ({ack, fifo_wr_cs, fifo_wr_en, fifo_data, busy, owner, stall_cnt} !== 34'd0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d: got ack=%b cs=%b en=%b data=%h busy=%b owner=%0d stall=%0d want all 0",
                 i, ack, fifo_wr_cs, fifo_wr_en, fifo_data, busy, owner, stall_cnt);
      end
    end
    rst = 1'b0;
    tick();
    #1;
    total++;
    if ({busy, owner, ack, fifo_wr_en, fifo_data} !== {1'b1, 2'd0, 4'b0001, 1'b1, 8'h11}) begin
      bad++;
      $display("FAIL first_grant: got busy=%b owner=%0d ack=%b en=%b data=%h want 1 0 0001 1 11",
               busy, owner, ack, fifo_wr_en, fifo_data);
    end
  endtask

  task automatic test_fairness;
    logic [1:0] exp_owner;
    logic [3:0] exp_ack;
    logic [7:0] exp_data;
    do_reset();
    req = 4'b1111;
    tick();
    for (int j = 0; j < 20; j++) begin
      exp_owner = 2'((j / 4) % 4);
      exp_ack   = 4'b0001 << exp_owner;
      exp_data  = 8'(8'h11 * (32'(exp_owner) + 1));
      #1;
      total++;
      if ({busy, owner, ack, fifo_wr_cs, fifo_wr_en, fifo_data} !==
          {1'b1, exp_owner, exp_ack, 1'b1, 1'b1, exp_data}) begin
        bad++;
        $display("FAIL fairness cyc%0d: got owner=%0d ack=%b cs=%b en=%b data=%h want owner=%0d ack=%b en=1 data=%h",
                 j, owner, ack, fifo_wr_cs, fifo_wr_en, fifo_data, exp_owner, exp_ack, exp_data);
      end
      tick();
    end
  endtask

  task automatic test_early_release;
    int acks2;
    acks2 = 0;
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0101;
    for (int j = 0; j < 2; j++) begin
      #1;
      acks2 += int'(ack[2]);
      total++;
      if ({owner, ack, fifo_data} !== {2'd2, 4'b0100, 8'h33}) begin
        bad++;
        $display("FAIL release_beat%0d: got owner=%0d ack=%b data=%h want 2 0100 33",
                 j, owner, ack, fifo_data);
      end
      tick();
    end
    req = 4'b0001;
    #1;
    acks2 += int'(ack[2]);
    total++;
    if ({ack, fifo_wr_en} !== {4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL release_drop: got ack=%b en=%b want 0000 0", ack, fifo_wr_en);
    end
    tick();
    #1;
    total++;
    if ({busy, owner, ack, fifo_data} !== {1'b1, 2'd0, 4'b0001, 8'h11}) begin
      bad++;
      $display("FAIL release_handover: got busy=%b owner=%0d ack=%b data=%h want 1 0 0001 11",
               busy, owner, ack, fifo_data);
    end
    total++;
    if (acks2 != 2) begin
      bad++;
      $display("FAIL release_ack_count: got %0d want 2", acks2);
    end
  endtask

  task automatic test_full_stall;
    logic [15:0] exp_stall;
`ifdef FIFO_ARB_STALL_CNT_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    req = 4'b0010;
    tick();
    #1;
    total++;
    if ({owner, ack, fifo_data} !== {2'd1, 4'b0010, 8'h22}) begin
      bad++;
      $display("FAIL stall_first_beat: got owner=%0d ack=%b data=%h want 1 0010 22",
               owner, ack, fifo_data);
    end
    tick();
    fifo_full = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      total++;
      if ({busy, owner, ack, fifo_wr_cs, fifo_wr_en} !== {1'b1, 2'd1, 4'b0000, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold%0d: got busy=%b owner=%0d ack=%b cs=%b en=%b want 1 1 0000 0 0",
                 j, busy, owner, ack, fifo_wr_cs, fifo_wr_en);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++;
      if ({owner, ack, fifo_wr_en, fifo_data} !== {2'd1, 4'b0010, 1'b1, 8'h22}) begin
        bad++;
        $display("FAIL stall_resume%0d: got owner=%0d ack=%b en=%b data=%h want 1 0010 1 22",
                 j, owner, ack, fifo_wr_en, fifo_data);
      end
      tick();
    end
    #1;
    total++;
    if (stall_cnt !== exp_stall) begin
      bad++;
      $display("FAIL stall_count: got %0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_sole_and_reset;
    do_reset();
    req = 4'b1000;
    tick();
    for (int j = 0; j < 10; j++) begin
      #1;
      total++;
      if ({busy, owner, ack, fifo_wr_en, fifo_data} !== {1'b1, 2'd3, 4'b1000, 1'b1, 8'h44}) begin
        bad++;
        $display("FAIL sole_regrant%0d: got busy=%b owner=%0d ack=%b en=%b data=%h want 1 3 1000 1 44",
                 j, busy, owner, ack, fifo_wr_en, fifo_data);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    #1;
    total++;
    if ({busy, owner, ack, fifo_wr_cs, fifo_wr_en, fifo_data} !== 17'd0) begin
      bad++;
      $display("FAIL midburst_reset: got busy=%b owner=%0d ack=%b cs=%b en=%b data=%h want all 0",
               busy, owner, ack, fifo_wr_cs, fifo_wr_en, fifo_data);
    end
    rst = 1'b0;
    req = 4'b0110;
    tick();
    #1;
    total++;
    if ({busy, owner, ack, fifo_data} !== {1'b1, 2'd1, 4'b0010, 8'h22}) begin
      bad++;
      $display("FAIL post_reset_grant: got busy=%b owner=%0d ack=%b data=%h want 1 1 0010 22",
               busy, owner, ack, fifo_data);
    end
    req = 4'b0000;
    tick();
    tick();
    #1;
    total++;
    if ({busy, owner, ack, fifo_wr_en, fifo_data} !== 16'd0) begin
      bad++;
      $display("FAIL idle_outputs: got busy=%b owner=%0d ack=%b en=%b data=%h want all 0",
               busy, owner, ack, fifo_wr_en, fifo_data);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'b0000;
    fifo_full = 1'b0;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    test_reset();
    test_fairness();
    test_early_release();
    test_full_stall();
    test_sole_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
